// File: rtl/mem_io_responder.sv
// Byte-wide memory-bus target: synchronous byte RAM plus an IO window at mem_a[17:16] == 2'b11
// holding a UART TX FIFO, a one-entry RX holding register and a status byte.
module mem_io_responder #(
  parameter int unsigned RAM_ADDR_WID = 17,
  parameter int unsigned TX_DEPTH     = 16,
  parameter int unsigned TX_PTR_WID   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        tx_overflow
);

  localparam int unsigned CNT_W = TX_PTR_WID + 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(TX_DEPTH - 2);
  localparam logic [2:0] OFS_DATA   = 3'd0;
  localparam logic [2:0] OFS_STATUS = 3'd4;

  logic [7:0] ram    [0:(1 << RAM_ADDR_WID) - 1];
  logic [7:0] tx_mem [0:TX_DEPTH - 1];

  logic [TX_PTR_WID-1:0] tx_rd_ptr;
  logic [TX_PTR_WID-1:0] tx_wr_ptr;
  logic [CNT_W-1:0]      tx_count;
  logic [7:0]            rx_hold;
  logic                  rx_full;

  logic                    is_io;
  logic [2:0]              io_ofs;
  logic [RAM_ADDR_WID-1:0] ram_idx;
  logic                    io_data_wr;
  logic                    tx_push;
  logic                    tx_drop;
  logic                    tx_pop;
  logic                    rx_pop;
  logic                    rx_load;
  logic [7:0]              rd_data;

  // Only mem_a[17:0] is decoded; fold the rest in so no bit is left dangling.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_a;

  assign uart_tx_valid  = (tx_count != '0);
  assign uart_tx_data   = tx_mem[tx_rd_ptr];
  assign io_buffer_full = (tx_count >= FULL_THRESH);

  // Address decode and per-cycle bus actions.
  always_comb begin
    is_io      = (mem_a[17:16] == 2'b11);
    io_ofs     = mem_a[2:0];
    ram_idx    = mem_a[RAM_ADDR_WID-1:0];
    io_data_wr = is_io && (io_ofs == OFS_DATA) && mem_wr;
    tx_push    = io_data_wr && (tx_count != CNT_MAX);
    tx_drop    = io_data_wr && (tx_count == CNT_MAX);
    tx_pop     = uart_tx_valid && uart_tx_ready;
    rx_pop     = is_io && (io_ofs == OFS_DATA) && !mem_wr;
    // A strobe coinciding with a DATA read refills the slot the read empties.
    rx_load    = uart_rx_valid && (!rx_full || rx_pop);
  end

  // Read data selection for the registered mem_din.
  always_comb begin
    rd_data = 8'h00;
    if (!is_io) begin
      rd_data = ram[ram_idx];
    end else begin
      case (io_ofs)
        OFS_DATA:   rd_data = rx_full ? rx_hold : 8'h00;
        OFS_STATUS: rd_data = {4'b0000, tx_overflow, rx_full, io_buffer_full, uart_tx_valid};
        default:    rd_data = 8'h00;
      endcase
    end
  end

  // RAM and FIFO storage are not reset.
  always_ff @(posedge clk) begin
    if (mem_wr && !is_io) ram[ram_idx] <= mem_dout;
    if (tx_push) tx_mem[tx_wr_ptr] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_din     <= 8'h00;
      tx_rd_ptr   <= '0;
      tx_wr_ptr   <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
      rx_hold     <= 8'h00;
      rx_full     <= 1'b0;
    end else begin
      if (!mem_wr) mem_din <= rd_data;

      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PTR_WID'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PTR_WID'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_W'(1);
        2'b01:   tx_count <= tx_count - CNT_W'(1);
        default: tx_count <= tx_count;
      endcase
      if (tx_drop) tx_overflow <= 1'b1;

      if (rx_load) begin
        rx_hold <= uart_rx_data;
        rx_full <= 1'b1;
      end else if (rx_pop) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a queue/array-level model checked every cycle,
// plus hand-computed literal checks at the interesting points.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        tx_overflow;

  mem_io_responder dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: sparse RAM, TX byte queue, RX slot, sticky overflow, expected read byte.
  logic [7:0] ram_m [int];
  logic [7:0] txq [$];
  bit         m_ovf, m_rxf, m_din_known;
  logic [7:0] m_rxh, m_din;

  always @(posedge clk) begin : model
    logic [7:0] rv;
    bit         rv_known, io, dread, popq;
    logic [2:0] ofs;
    int         idx, sz;
    if (rst) begin
      txq.delete();
      m_ovf = 0; m_rxf = 0; m_rxh = 8'h00; m_din = 8'h00; m_din_known = 1;
    end else begin
      io    = (mem_a[17:16] == 2'b11);
      ofs   = mem_a[2:0];
      idx   = int'(mem_a[16:0]);
      sz    = txq.size();
      popq  = (sz > 0) && uart_tx_ready;
      dread = io && !mem_wr && (ofs == 3'd0);
      rv = 8'h00; rv_known = 1;
      if (!io) begin
        if (ram_m.exists(idx)) rv = ram_m[idx];
        else rv_known = 0;
      end else if (ofs == 3'd0) begin
        rv = m_rxf ? m_rxh : 8'h00;
      end else if (ofs == 3'd4) begin
        rv = {4'b0000, m_ovf, m_rxf, sz >= 14, sz > 0};
      end
      if (mem_wr) begin
        if (!io) ram_m[idx] = mem_dout;
        else if (ofs == 3'd0 && sz == 16) m_ovf = 1;
      end else begin
        m_din = rv; m_din_known = rv_known;
      end
      if (popq) void'(txq.pop_front());
      if (mem_wr && io && ofs == 3'd0 && sz < 16) txq.push_back(mem_dout);
      if (uart_rx_valid && (!m_rxf || dread)) begin
        m_rxh = uart_rx_data; m_rxf = 1;
      end else if (dread) begin
        m_rxf = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("m_tx_valid", uart_tx_valid, txq.size() > 0);
      check1("m_io_full", io_buffer_full, txq.size() >= 14);
      check1("m_overflow", tx_overflow, m_ovf);
      if (txq.size() > 0) check8("m_tx_data", uart_tx_data, txq[0]);
      if (m_din_known) check8("m_mem_din", mem_din, m_din);
    end
  end

  // One bus cycle: inputs applied at a falling edge, result visible at the next one.
  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a = a; mem_wr = wr; mem_dout = d;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
  endtask

  task automatic strobe(input logic [7:0] d);
    uart_rx_data = d; uart_rx_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_head [3];
    exp_head[0] = 8'h04; exp_head[1] = 8'h05; exp_head[2] = 8'h06;

    repeat (2) @(negedge clk);
    rst = 1'b0; chk_en = 1'b1;
    check8("rst_din", mem_din, 8'h00);
    check1("rst_valid", uart_tx_valid, 1'b0);
    check1("rst_full", io_buffer_full, 1'b0);
    check1("rst_ovf", tx_overflow, 1'b0);

    // RAM round trip and boundaries
    bus(32'h0, 1'b1, 8'h11);
    bus(32'h10, 1'b1, 8'hA5);
    bus(32'h11, 1'b1, 8'h3C);
    bus(32'h10, 1'b0, 8'h00);   check8("ram_rd_10", mem_din, 8'hA5);
    bus(32'h11, 1'b0, 8'h00);   check8("ram_rd_11", mem_din, 8'h3C);
    bus(32'h1FFFF, 1'b1, 8'h7E); check8("wr_holds_din", mem_din, 8'h3C);
    bus(32'h1FFFF, 1'b0, 8'h00); check8("ram_rd_top", mem_din, 8'h7E);
    bus(32'h0, 1'b0, 8'h00);    check8("ram_rd_0", mem_din, 8'h11);
    check1("ram_not_io", uart_tx_valid, 1'b0);

    // TX fill with the UART stalled
    uart_tx_ready = 1'b0;
    for (int i = 1; i <= 13; i++) bus(32'h30000, 1'b1, 8'(i));
    check1("full_at_13", io_buffer_full, 1'b0);
    bus(32'h30000, 1'b1, 8'd14); check1("full_at_14", io_buffer_full, 1'b1);
    bus(32'h30000, 1'b1, 8'd15);
    bus(32'h30000, 1'b1, 8'd16); check1("ovf_at_16", tx_overflow, 1'b0);
    bus(32'h30000, 1'b1, 8'd17); check1("ovf_at_17", tx_overflow, 1'b1);
    bus(32'h30004, 1'b1, 8'hFF);
    bus(32'h30002, 1'b1, 8'hFF);
    bus(32'h30004, 1'b0, 8'h00); check8("status_full", mem_din, 8'h0B);
    check8("head_full", uart_tx_data, 8'h01);
    uart_tx_ready = 1'b1;
    repeat (16) bus(32'h0, 1'b0, 8'h00);
    check1("drained", uart_tx_valid, 1'b0);
    check1("ovf_sticky", tx_overflow, 1'b1);

    // TX drain with a push during a pop
    uart_tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus(32'h30000, 1'b1, 8'(i));
    check8("drain_head1", uart_tx_data, 8'h01);
    uart_tx_ready = 1'b1;
    bus(32'h0, 1'b0, 8'h00);     check8("drain_head2", uart_tx_data, 8'h02);
    bus(32'h30000, 1'b1, 8'h06); check8("drain_head3", uart_tx_data, 8'h03);
    for (int i = 0; i < 3; i++) begin
      bus(32'h0, 1'b0, 8'h00);
      check8("drain_seq", uart_tx_data, exp_head[i]);
    end
    bus(32'h0, 1'b0, 8'h00);     check1("drain_empty", uart_tx_valid, 1'b0);
    uart_tx_ready = 1'b0;

    // RX holding register
    strobe(8'h41); bus(32'h0, 1'b0, 8'h00);
    bus(32'h30004, 1'b0, 8'h00); check1("rx_full_set", mem_din[2], 1'b1);
    strobe(8'h42); bus(32'h30002, 1'b0, 8'h00); check8("unmapped_rd", mem_din, 8'h00);
    bus(32'h30000, 1'b0, 8'h00); check8("rx_first", mem_din, 8'h41);
    bus(32'h30004, 1'b0, 8'h00); check1("rx_full_clr", mem_din[2], 1'b0);
    bus(32'h30000, 1'b0, 8'h00); check8("rx_empty_rd", mem_din, 8'h00);
    strobe(8'h50); bus(32'h0, 1'b0, 8'h00);
    strobe(8'h51); bus(32'h30000, 1'b0, 8'h00); check8("rx_same_cyc_old", mem_din, 8'h50);
    bus(32'h30004, 1'b0, 8'h00); check1("rx_still_full", mem_din[2], 1'b1);
    bus(32'h30000, 1'b0, 8'h00); check8("rx_same_cyc_new", mem_din, 8'h51);

    // Reset mid-operation
    for (int i = 0; i < 10; i++) bus(32'h30000, 1'b1, 8'(8'hC0 + i));
    check1("pre_rst_valid", uart_tx_valid, 1'b1);
    rst = 1'b1;
    bus(32'h0, 1'b0, 8'h00);
    rst = 1'b0;
    check1("mid_rst_valid", uart_tx_valid, 1'b0);
    check1("mid_rst_full", io_buffer_full, 1'b0);
    check1("mid_rst_ovf", tx_overflow, 1'b0);
    check8("mid_rst_din", mem_din, 8'h00);
    bus(32'h10, 1'b0, 8'h00);    check8("ram_kept", mem_din, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus (mem_a / mem_wr / mem_dout / mem_din / io_buffer_full), i.e. the target the memory controller drives.
- Implements a synchronous byte RAM plus a memory-mapped IO region (mem_a[17:16] == 2'b11).
- The IO region contains a UART TX FIFO that generates io_buffer_full, a one-entry UART RX holding register, and a status byte.
- Used in simulation top-levels and FPGA builds in place of board RAM and UART glue.

Parameters:
RAM_ADDR_WID, 17, byte address bits for RAM; RAM depth is 2^RAM_ADDR_WID bytes; index is mem_a[RAM_ADDR_WID-1:0]
TX_DEPTH, 16, TX FIFO entries (power of two, >= 4)
TX_PTR_WID, 4, log2(TX_DEPTH)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
mem_a  input  32  byte address from controller; only [17:0] decoded
mem_wr  input  1  1 = write mem_dout to mem_a this cycle
mem_dout  input  8  write data from controller
mem_din  output  8  read data to controller, registered
io_buffer_full  output  1  TX FIFO cannot safely accept a write issued next cycle
uart_tx_data  output  8  head of TX FIFO
uart_tx_valid  output  1  TX FIFO non-empty
uart_tx_ready  input  1  UART consumes head when valid && ready
uart_rx_data  input  8  received byte
uart_rx_valid  input  1  one-cycle strobe: uart_rx_data is valid
tx_overflow  output  1  sticky: an IO write was dropped because the FIFO was full

Behaviour:
- Address decode:
  - is_io = (mem_a[17:16] == 2'b11).
  - IO offsets use mem_a[2:0]: 0 = DATA, 4 = STATUS; other offsets are unmapped.
- Read timing:
  - mem_din is registered. The value at edge N+1 reflects mem_a sampled at edge N, giving 1-cycle latency.
  - Back-to-back addresses stream one byte per cycle.
  - mem_a == 0 is a legal read of RAM[0]; the controller parks on 0, so idle reads are harmless.
- Read data when mem_wr == 0:
  - RAM: mem_din <= RAM[idx].
  - IO DATA: mem_din <= rx_hold if rx_full, else 8'h00. Sets rx_full <= 0 (pop).
  - IO STATUS: mem_din <= {4'b0, tx_overflow, rx_full, io_buffer_full, uart_tx_valid}.
  - IO unmapped: mem_din <= 8'h00.
- Write when mem_wr == 1:
  - RAM: RAM[idx] <= mem_dout at the edge. mem_din holds its previous value.
  - IO DATA: push mem_dout into the TX FIFO. If count == TX_DEPTH, drop the byte and set tx_overflow.
  - IO STATUS or unmapped: ignored.
  - Reads have no side effects during a write cycle.
- TX FIFO:
  - Circular buffer with rd_ptr and wr_ptr (TX_PTR_WID bits, wrap modulo TX_DEPTH) and count (TX_PTR_WID+1 bits).
  - Push and pop in the same cycle leave count unchanged. Pop when empty cannot occur because valid is low.
  - uart_tx_valid = (count != 0); uart_tx_data = mem[rd_ptr]. Both are combinational from registers.
  - io_buffer_full = (count >= TX_DEPTH-2), combinational from count. The margin covers the controller's one registered write already in flight after it sampled full low.
- RX holding register:
  - When uart_rx_valid is high and rx_full is low: rx_hold <= uart_rx_data and rx_full <= 1.
  - When uart_rx_valid is high and rx_full is high: the new byte is dropped.
  - If an RX strobe and a DATA read occur in the same cycle, the read returns the old byte and the new byte is loaded (rx_full stays 1).
- Reset values:
  - mem_din = 0, TX count and pointers = 0, uart_tx_valid = 0, io_buffer_full = 0, tx_overflow = 0, rx_full = 0, rx_hold = 0.
  - RAM contents are not reset.
  - Reset mid-transfer discards the FIFO contents and any pending read.
- No internal FSM beyond FIFO/RX state. Every bus cycle is independent; the responder never stalls reads.

Test Plan:
- RAM round trip: write 8'hA5 @0x00010, 8'h3C @0x00011, then read 0x00010, 0x00011 on consecutive cycles -> mem_din = A5 one cycle after the first address, then 3C the next cycle.
- Boundary: write 8'h7E @0x1FFFF, read 0x1FFFF -> 7E. Read 0x00000 after reset on a fresh write 8'h11 -> 11. RAM addresses are not aliased into IO.
- TX fill with uart_tx_ready = 0: 14 writes to 0x30000 -> io_buffer_full rises when count = 14. Writes 15 and 16 are accepted. Write 17 is dropped and tx_overflow = 1, sticky through later traffic until rst.
- TX drain: FIFO holds 01..05, then uart_tx_ready = 1 -> bytes 01,02,03,04,05 appear in order, one per cycle, then valid drops. Simultaneous push 06 while popping keeps count constant and 06 follows 05.
- RX: strobe 8'h41 -> STATUS read bit2 = 1. DATA read returns 41, then STATUS bit2 = 0. A second strobe 8'h42 while full is dropped (a later read returns 41, not 42).
- Reset mid-operation: FIFO count 10, assert rst one cycle -> uart_tx_valid = 0, io_buffer_full = 0, tx_overflow = 0, mem_din = 0 on the next cycle. A previously written RAM byte is still readable.
